// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths and FSM state type for the data cache controller
package dcache_pkg;
    localparam int ADDR_W         = 10;
    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/tag/data storage with one read, one line-write and one word-write port
module dcache_line_array #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_BITS       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(NUM_LINES)-1:0]      i_rd_idx,
    output logic                              o_rd_valid,
    output logic [TAG_BITS-1:0]               o_rd_tag,
    output logic [32*WORDS_PER_LINE-1:0]      o_rd_line,
    input  logic                              i_line_we,
    input  logic [$clog2(NUM_LINES)-1:0]      i_line_idx,
    input  logic [TAG_BITS-1:0]               i_line_tag,
    input  logic [32*WORDS_PER_LINE-1:0]      i_line_data,
    input  logic                              i_word_we,
    input  logic [$clog2(NUM_LINES)-1:0]      i_word_idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] i_word_off,
    input  logic [31:0]                       i_word_data
);
    import dcache_pkg::*;

    logic [NUM_LINES-1:0]            r_valid;
    logic [TAG_BITS-1:0]             r_tag  [NUM_LINES];
    logic [32*WORDS_PER_LINE-1:0]    r_data [NUM_LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

    // valid bits: cleared by reset, set when a fill lands
    always_ff @(posedge clk) begin
        if (rst) r_valid <= '0;
        else if (i_line_we) r_valid[i_line_idx] <= 1'b1;
    end

    // tag/data storage needs no reset; a fill rewrites the whole line, a store patches one word
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_line_idx]  <= i_line_tag;
            r_data[i_line_idx] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_word_idx][i_word_off*WORD_W +: WORD_W] <= i_word_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-through, no-write-allocate data cache FSM
module dcache_controller #(
    parameter int ADDR_W         = 10,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         memread,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         stall,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                         mem_ready
);
    import dcache_pkg::*;

    localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS;
    localparam int LINE_BITS = WORD_W * WORDS_PER_LINE;

    state_t                r_state;
    state_t                w_next;
    logic [OFF_BITS-1:0]   w_off;
    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_valid;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [LINE_BITS-1:0]  w_rd_line;
    logic                  w_hit;
    logic                  w_line_we;
    logic                  w_word_we;

    assign w_off     = addr[OFF_BITS-1:0];
    assign w_idx     = addr[OFF_BITS +: IDX_BITS];
    assign w_tag     = addr[ADDR_W-1 -: TAG_BITS];
    assign w_hit     = w_valid && (w_rd_tag == w_tag);
    assign mem_wdata = wdata;

    dcache_line_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .o_rd_valid  (w_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_line   (w_rd_line),
        .i_line_we   (w_line_we),
        .i_line_idx  (w_idx),
        .i_line_tag  (w_tag),
        .i_line_data (mem_rdata),
        .i_word_we   (w_word_we),
        .i_word_idx  (w_idx),
        .i_word_off  (w_off),
        .i_word_data (wdata)
    );

    // state register; reset aborts any outstanding memory access
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state and outputs; everything is held quiet while reset is asserted
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        rdata     = '0;
        w_line_we = 1'b0;
        w_word_we = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (memwrite) begin
                        stall  = 1'b1;
                        w_next = WRITE_WAIT;
                    end else if (memread) begin
                        stall  = !w_hit;
                        rdata  = w_hit ? w_rd_line[w_off*WORD_W +: WORD_W] : '0;
                        w_next = w_hit ? IDLE : READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    mem_rd    = 1'b1;
                    mem_addr  = {addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    stall     = !mem_ready;
                    w_line_we = mem_ready;
                    rdata     = mem_ready ? mem_rdata[w_off*WORD_W +: WORD_W] : '0;
                    w_next    = mem_ready ? IDLE : READ_WAIT;
                end
                WRITE_WAIT: begin
                    mem_wr    = 1'b1;
                    mem_addr  = addr;
                    stall     = !mem_ready;
                    w_word_we = mem_ready && w_hit;
                    w_next    = mem_ready ? IDLE : WRITE_WAIT;
                end
                default: w_next = IDLE;
            endcase
        end
    end
endmodule
